// File: rtl/parity_seq_ctrl.sv
// Purpose: sequences one nibble-wide masked-parity stage across a NIBBLES-nibble word, LSB nibble first.
// Latency: word accepted at edge k gives out_valid after edge k+NIBBLES; one word per NIBBLES+2 cycles at best.
// Backpressure: in_ready only in IDLE (no overlap); result held stable in DONE until out_valid & out_ready.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       input word handshake; in_data = word, in_en = per-bit parity enable
//   out_valid/out_ready     result handshake; out_dp = {parity, captured (unmasked) data}
//   busy                    high while a word is in flight (RUN or DONE)
// Build option: define PARITY_SEQ_ODD_EN for odd parity (accumulator seeds to 1 on acceptance).
module parity_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_data,
    input  logic [4*NIBBLES-1:0]   in_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES:0]     out_dp,
    output logic                   busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

`ifdef PARITY_SEQ_ODD_EN
    localparam logic ACC_INIT = 1'b1;
`else
    localparam logic ACC_INIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    data_q;
    logic [W-1:0]    en_q;
    logic            acc;
    logic [IW-1:0]   idx;

    logic [W-1:0]    masked_sh;
    logic            nib_par;

    // The single shared parity stage: select nibble idx of the masked word.
    always_comb begin
        masked_sh = (data_q & en_q) >> {idx, 2'b00};
        nib_par   = ^masked_sh[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            data_q <= '0;
            en_q   <= '0;
            acc    <= 1'b0;
            idx    <= '0;
            out_dp <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        en_q   <= in_en;
                        acc    <= ACC_INIT;
                        idx    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc ^ nib_par;
                    if (idx == LAST_IDX) begin
                        // Fold in the final nibble directly so the result is ready on DONE entry.
                        out_dp <= {acc ^ nib_par, data_q};
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake/status outputs are pure decodes of the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: doc/parity_seq_ctrl.md
# parity_seq_ctrl

Sequencing controller that time-multiplexes one nibble-wide masked-parity stage across a multi-nibble word. It accepts a data word and per-bit enable mask over a valid/ready handshake. It walks the word one nibble per cycle, least-significant nibble first, and accumulates parity over the enabled bits. It then presents `{parity, data}` on a valid/ready output. It sits upstream of the word-level parity consumers and replaces N parallel nibble parity chains with one sequenced stage.

## Interface

- `NIBBLES`, default 4: nibbles per word (≥1). Word width W = 4·NIBBLES.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: input word valid.
- `in_ready` output 1: controller can accept a word.
- `in_data` input W: data word.
- `in_en` input W: per-bit parity enable. Bit i contributes only when `in_en[i]`=1.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `out_dp` output W+1: `{parity, captured data}`. The data field is unmasked.
- `busy` output 1: high in RUN or DONE.

## Operation

- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`, capture `in_data` and `in_en`, clear the accumulator, set the nibble index to 0, and go to RUN.
- RUN:
  - Each cycle: `acc <= acc ^ ^(data_nib[idx] & en_nib[idx])`, then `idx <= idx+1`.
  - After nibble NIBBLES−1 is processed, go to DONE.
  - The index counter is $clog2(NIBBLES) bits, minimum 1. It never wraps past NIBBLES−1.
- DONE:
  - `out_valid`=1, and `out_dp` holds stable until handshake.
  - On `out_valid & out_ready`, go to IDLE.
- `in_ready` is 0 in RUN and DONE. There is no overlap of words.
- Captured registers are immune to input changes after acceptance.
- Parity is even by default: XOR of enabled bits. An all-zero mask gives parity 0.
- NIBBLES=1: RUN lasts exactly one cycle.

## Timing

- Reset values:
  - state=IDLE
  - `in_ready`=1
  - `out_valid`=0
  - `out_dp`=0
  - `busy`=0
  - accumulator and index = 0
  - captured data and enable = 0
- Reset mid-operation (RUN or DONE) aborts immediately. The in-flight word is discarded and no `out_valid` is produced.
- Latency: input accepted at edge k gives `out_valid` high after edge k+NIBBLES.
- `out_valid` drops after the handshake edge. `in_ready` rises in the same cycle, so the next word is accepted at the following edge at the earliest.
- Peak throughput: one word per NIBBLES+2 cycles with `out_ready` held high.
- `out_ready` asserted before DONE has no effect.
- `in_valid` while not ready is ignored. It is not queued.
- All outputs are registered, or decoded from the state register only. There are no combinational in→out paths.

## Configuration

- `PARITY_SEQ_ODD_EN`:
  - Defined: the accumulator clears to 1 on acceptance, so the reported parity is odd (XNOR of enabled bits). An all-zero mask gives parity 1.
  - Undefined: even parity as described above.
- Reset value of `out_dp` is 0 in both builds.

## Test plan

- NIBBLES=4, `in_data`=16'hA5F0, `in_en`=16'hFFFF (8 ones) → `out_dp`=17'h0A5F0, with `out_valid` high exactly 4 cycles after acceptance.
- `in_data`=16'h0007, `in_en`=16'h000F → `out_dp`=17'h10007.
- Same data with `in_en`=16'h0000 → `out_dp`=17'h00007, or 17'h10007 with `PARITY_SEQ_ODD_EN`.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles in DONE → `out_dp` stable, `in_ready`=0.
  - Toggle `in_data` during RUN → result unchanged.
  - A new `in_valid` in DONE is not accepted.
- Drive `rst_n` low at the 2nd RUN cycle → all outputs are at reset values immediately. After release, the next word (16'hFFFF, `in_en`=16'h0001) yields `out_dp`=17'h1FFFF.
- Back-to-back words with `in_valid` and `out_ready` held high → one result every 6 cycles. NIBBLES=1 build: `in_data`=4'hB, `in_en`=4'hF → `out_dp`=5'h1B after 1 cycle.
